adder_arbiter: RTL

Shares one registered adder datapath (operands `a`,`b`, sum out, one clock of register latency) between `N_REQ` requesters. Round-robin arbitration, valid/ready handshake per requester and a single tagged response channel. Sits between the operand producers and the adder instance and owns the adder's operand inputs. Exactly one operation is in flight at a time.

---
 rtl/adder_arb_pkg.sv | 15 +
 rtl/adder_rr_arbiter.sv | 32 +++
 rtl/adder_arbiter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/adder_arb_pkg.sv
// Shared types and defaults for the adder arbiter slice.
// FSM state encoding and default parameter values.
package adder_arb_pkg;

  localparam int DEF_N_REQ = 4;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_ADD_LAT = 1;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_WAIT,
    ARB_RESP
  } arb_state_t;

endpackage

// File: rtl/adder_rr_arbiter.sv
// Combinational round-robin grant; search starts one past ptr.
// Pointer storage lives in the parent.
module adder_rr_arbiter
  import adder_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int IDW = $clog2(DEF_N_REQ)
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [IDW-1:0]   ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IDW-1:0]   idx,
  output logic             any
);

  always_comb begin
    int j;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      j = (int'(ptr) + k) % N_REQ;
      if (!any && valid[j]) begin
        any = 1'b1;
        gnt[j] = 1'b1;
        idx = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin sharing of one registered adder among N_REQ requesters.
// Optional X-check on the captured sum: define ADDER_ARB_XCHECK_EN.
module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int WIDTH = DEF_WIDTH,
  parameter int ADD_LAT = DEF_ADD_LAT,
  localparam int IDW = $clog2(N_REQ),
  localparam int CW = $clog2(ADD_LAT + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic [WIDTH-1:0]       add_a,
  output logic [WIDTH-1:0]       add_b,
  input  logic [WIDTH:0]         add_sum,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [IDW-1:0]         resp_id,
  output logic [WIDTH:0]         resp_sum,
  output logic                   x_err
);

  arb_state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [IDW-1:0] ptr;
  logic [N_REQ-1:0] gnt;
  logic [IDW-1:0] gidx;
  logic gany;
  logic hs;
  logic cap;
  logic done;
  logic [WIDTH:0] cap_sum;

  adder_rr_arbiter #(
    .N_REQ(N_REQ),
    .IDW(IDW)
  ) u_rr (
    .valid(req_valid),
    .ptr(ptr),
    .gnt(gnt),
    .idx(gidx),
    .any(gany)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ARB_IDLE;
    else state <= state_n;
  end

  always_comb begin
    state_n = state;
    req_ready = '0;
    hs = 1'b0;
    cap = 1'b0;
    done = 1'b0;
    unique case (state)
      ARB_IDLE: begin
        if (!rst) req_ready = gnt;
        if (gany) begin
          hs = 1'b1;
          state_n = ARB_WAIT;
        end
      end
      ARB_WAIT: begin
        if (cnt == '0) begin
          cap = 1'b1;
          state_n = ARB_RESP;
        end
      end
      ARB_RESP: begin
        if (resp_ready) begin
          done = 1'b1;
          state_n = ARB_IDLE;
        end
      end
      default: state_n = ARB_IDLE;
    endcase
  end

  // ptr doubles as the in-flight grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      ptr <= IDW'(N_REQ - 1);
      add_a <= '0;
      add_b <= '0;
      resp_valid <= 1'b0;
      resp_id <= '0;
      resp_sum <= '0;
    end else begin
      if (hs) begin
        cnt <= CW'(ADD_LAT);
        ptr <= gidx;
        add_a <= req_a[int'(gidx)*WIDTH +: WIDTH];
        add_b <= req_b[int'(gidx)*WIDTH +: WIDTH];
      end else if (state == ARB_WAIT && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (cap) begin
        resp_valid <= 1'b1;
        resp_id <= ptr;
        resp_sum <= cap_sum;
      end else if (done) begin
        resp_valid <= 1'b0;
      end
    end
  end

`ifdef ADDER_ARB_XCHECK_EN
  logic sum_bad;
  assign sum_bad = (^add_sum === 1'bx);
  assign cap_sum = sum_bad ? '0 : add_sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) x_err <= 1'b0;
    else if (cap && sum_bad) x_err <= 1'b1;
  end
`else
  assign cap_sum = add_sum;
  assign x_err = 1'b0;
`endif

endmodule
